// File: rtl/dcmac_link_sequencer.sv
// AXI4-Lite initiator that sequences DCMAC bring-up: QSFP power, RS-FEC, loopback, reset, then status polling.
// Define LINK_MONITOR_EN to keep polling after link-up and recover from a lost link.
module dcmac_link_sequencer #(
  parameter int AW            = 8,
  parameter int POLL_INTERVAL = 4096,
  parameter int LINK_TIMEOUT  = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          cfg_rsfec,
  input  logic          cfg_loopback,
  output logic          busy,
  output logic          link_up,
  output logic          failed,
  output logic          link_lost,
  output logic [3:0]    retry_count,
  output logic [1:0]    err_resp,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic [2:0]    M_AXI_AWPROT,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic [2:0]    M_AXI_ARPROT,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

`ifdef LINK_MONITOR_EN
  localparam bit MON_EN = 1'b1;
`else
  localparam bit MON_EN = 1'b0;
`endif

  localparam int WCW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int PCW = $clog2(LINK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_QSFP, S_W_RSFEC, S_W_LOOP, S_W_RESET, S_WAIT, S_R_STAT, S_UP, S_FAILED
  } state_t;

  state_t state_q, state_d;

  logic           issued;
  logic           cfg_rsfec_q, cfg_loop_q;
  logic [WCW-1:0] wait_cnt;
  logic [PCW-1:0] poll_cnt, poll_inc;
  logic [3:0]     retry_inc;
  logic           is_wr, is_rd, busy_c;
  logic [AW-1:0]  wr_addr;
  logic [31:0]    wr_data;
  logic           wr_done, rd_done, wr_err, rd_err, rd_aligned, start_ok;
  logic           unused_rdata;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;
  assign unused_rdata = ^M_AXI_RDATA[31:2];

  assign wr_done    = M_AXI_BREADY && M_AXI_BVALID;
  assign rd_done    = M_AXI_RREADY && M_AXI_RVALID;
  assign wr_err     = wr_done && (M_AXI_BRESP != 2'b00);
  assign rd_err     = rd_done && (M_AXI_RRESP != 2'b00);
  assign rd_aligned = (M_AXI_RDATA[1:0] == 2'b11);
  assign poll_inc   = poll_cnt + PCW'(1);
  assign retry_inc  = retry_count + 4'd1;
  assign start_ok   = start && !busy_c;
  assign busy       = busy_c;
  assign failed     = (state_q == S_FAILED);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FAILED: if (start) state_d = S_W_QSFP;
      S_W_QSFP:  if (wr_err) state_d = S_FAILED; else if (wr_done) state_d = S_W_RSFEC;
      S_W_RSFEC: if (wr_err) state_d = S_FAILED; else if (wr_done) state_d = S_W_LOOP;
      S_W_LOOP:  if (wr_err) state_d = S_FAILED; else if (wr_done) state_d = S_W_RESET;
      S_W_RESET: if (wr_err) state_d = S_FAILED; else if (wr_done) state_d = S_WAIT;
      S_WAIT:    if (wait_cnt == '0) state_d = S_R_STAT;
      S_R_STAT: begin
        if (rd_err) state_d = S_FAILED;
        else if (rd_done) begin
          if (rd_aligned)                           state_d = S_UP;
          else if (MON_EN && link_up)               state_d = S_W_RESET;
          else if (poll_inc < PCW'(LINK_TIMEOUT))   state_d = S_WAIT;
          else if (retry_inc == 4'(MAX_RETRIES))    state_d = S_FAILED;
          else                                      state_d = S_W_RESET;
        end
      end
      // With monitoring UP is a polling wait; without it UP is terminal until restarted.
      S_UP: begin
        if (MON_EN) begin
          if (wait_cnt == '0) state_d = S_R_STAT;
        end else if (start) begin
          state_d = S_W_QSFP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c  = 1'b1;
    is_wr   = 1'b0;
    is_rd   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_IDLE, S_FAILED: busy_c = 1'b0;
      S_W_QSFP:  begin is_wr = 1'b1; wr_addr = AW'('h10); wr_data = 32'd1; end
      S_W_RSFEC: begin is_wr = 1'b1; wr_addr = AW'('h0C); wr_data = {31'd0, cfg_rsfec_q}; end
      S_W_LOOP:  begin is_wr = 1'b1; wr_addr = AW'('h08); wr_data = {31'd0, cfg_loop_q}; end
      S_W_RESET: begin is_wr = 1'b1; wr_addr = AW'('h04); wr_data = 32'd1; end
      S_R_STAT:  is_rd = 1'b1;
      S_UP:      busy_c = MON_EN;
      default:   busy_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      issued        <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      cfg_rsfec_q   <= 1'b0;
      cfg_loop_q    <= 1'b0;
      wait_cnt      <= '0;
      poll_cnt      <= '0;
      retry_count   <= 4'd0;
      err_resp      <= 2'b00;
      link_up       <= 1'b0;
      link_lost     <= 1'b0;
    end else begin
      link_lost <= 1'b0;

      // AW and W launch together and retire independently; BREADY follows the later one.
      if (is_wr && !issued) begin
        issued        <= 1'b1;
        M_AXI_AWVALID <= 1'b1;
        M_AXI_WVALID  <= 1'b1;
        M_AXI_AWADDR  <= wr_addr;
        M_AXI_WDATA   <= wr_data;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
      if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
      if (is_wr && issued && !M_AXI_BREADY &&
          (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
        M_AXI_BREADY <= 1'b1;
      if (wr_done) begin
        M_AXI_BREADY <= 1'b0;
        issued       <= 1'b0;
      end

      if (is_rd && !issued) begin
        issued        <= 1'b1;
        M_AXI_ARVALID <= 1'b1;
        M_AXI_ARADDR  <= '0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b1;
      end
      if (rd_done) begin
        M_AXI_RREADY <= 1'b0;
        issued       <= 1'b0;
      end

      if ((state_d == S_WAIT || state_d == S_UP) && state_d != state_q)
        wait_cnt <= WCW'(POLL_INTERVAL - 1);
      else if ((state_q == S_WAIT || state_q == S_UP) && wait_cnt != '0)
        wait_cnt <= wait_cnt - WCW'(1);

      if (start_ok) begin
        cfg_rsfec_q <= cfg_rsfec;
        cfg_loop_q  <= cfg_loopback;
        err_resp    <= 2'b00;
        retry_count <= 4'd0;
        poll_cnt    <= '0;
        link_up     <= 1'b0;
      end

      if (wr_err) begin
        err_resp <= M_AXI_BRESP;
        link_up  <= 1'b0;
      end

      if (rd_err) begin
        err_resp <= M_AXI_RRESP;
        link_up  <= 1'b0;
      end else if (rd_done) begin
        if (rd_aligned) begin
          link_up  <= 1'b1;
          poll_cnt <= '0;
        end else if (MON_EN && link_up) begin
          link_lost   <= 1'b1;
          link_up     <= 1'b0;
          retry_count <= 4'd0;
          poll_cnt    <= '0;
        end else if (poll_inc < PCW'(LINK_TIMEOUT)) begin
          poll_cnt <= poll_inc;
        end else begin
          poll_cnt    <= '0;
          retry_count <= retry_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcmac_link_sequencer.sv
// Scoreboarded bench for dcmac_link_sequencer: an AXI4-Lite slave model checks each write against a queue of expected writes.
`timescale 1ns/1ps
module tb_dcmac_link_sequencer;
  localparam int AW = 8;
  localparam int PI = 8;
  localparam int LT = 2;
  localparam int MR = 3;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, cfg_rsfec = 1'b0, cfg_loopback = 1'b0;
  logic busy, link_up, failed, link_lost;
  logic [3:0] retry_count;
  logic [1:0] err_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0] M_AXI_WSTRB;
  logic M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0] M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'd0;

  dcmac_link_sequencer #(.AW(AW), .POLL_INTERVAL(PI), .LINK_TIMEOUT(LT), .MAX_RETRIES(MR)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cfg_rsfec(cfg_rsfec), .cfg_loopback(cfg_loopback),
    .busy(busy), .link_up(link_up), .failed(failed), .link_lost(link_lost),
    .retry_count(retry_count), .err_resp(err_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int n_writes = 0, n_reads = 0, n_drop = 0, n_lost = 0, cyc = 0, last_b_cyc = 0, ar_cyc = 0;
  int r_delay = 0, r0 = 0, w0 = 0;
  bit rand_mode = 1'b0, stall_aw = 1'b0, err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [1:0] link_status = 2'b00;
  logic [39:0] exp_wq[$];

  logic aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0;
  logic [AW-1:0] aw_addr_s = '0;
  logic [31:0] w_data_s = '0, nr_data = '0;
  logic nb_valid = 1'b0, nr_valid = 1'b0;
  logic [1:0] nb_resp = 2'b00;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    exp_wq.push_back({a, d});
  endtask

  task automatic score_write(input logic [AW-1:0] a, input logic [31:0] d);
    logic [39:0] e;
    if (exp_wq.size() == 0) begin
      chk("wr_unexpected", 40'({a, d}), 40'hFF_FFFF_FFFF);
    end else begin
      e = exp_wq.pop_front();
      chk("wr_addr", 40'(a), 40'(e[39:32]));
      chk("wr_data", 40'(d), 40'(e[31:0]));
    end
  endtask

  // Slave model: decisions use pre-edge values, new responses are driven 1 ns after the edge.
  always begin : slave
    @(posedge clk);
    cyc++;
    aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    b_hs  = M_AXI_BVALID && M_AXI_BREADY;
    ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    r_hs  = M_AXI_RVALID && M_AXI_RREADY;
    if (link_lost) n_lost++;
    if ((aw_pend && !M_AXI_AWVALID) || (w_pend && !M_AXI_WVALID) || (ar_pend && !M_AXI_ARVALID))
      n_drop++;
    aw_pend = resetn && M_AXI_AWVALID && !M_AXI_AWREADY;
    w_pend  = resetn && M_AXI_WVALID && !M_AXI_WREADY;
    ar_pend = resetn && M_AXI_ARVALID && !M_AXI_ARREADY;
    if (!resetn) begin
      aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0; nb_valid = 1'b0; nr_valid = 1'b0;
    end else begin
      if (aw_hs) begin aw_got = 1'b1; aw_addr_s = M_AXI_AWADDR; end
      if (w_hs)  begin w_got = 1'b1;  w_data_s = M_AXI_WDATA; end
      if (b_hs)  begin nb_valid = 1'b0; n_writes++; last_b_cyc = cyc; end
      if (aw_got && w_got && !nb_valid) begin
        score_write(aw_addr_s, w_data_s);
        nb_valid = 1'b1;
        nb_resp  = (err_en && aw_addr_s == err_addr) ? 2'b10 : 2'b00;
        aw_got = 1'b0; w_got = 1'b0;
      end
      if (ar_hs) begin
        n_reads++; ar_cyc = cyc; r_pend = 1'b1;
        r_delay = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end
      if (r_hs) nr_valid = 1'b0;
      if (r_pend) begin
        if (r_delay == 0) begin nr_valid = 1'b1; nr_data = {30'd0, link_status}; r_pend = 1'b0; end
        else r_delay--;
      end
    end
    #1;
    M_AXI_AWREADY = resetn && !stall_aw && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    M_AXI_WREADY  = resetn && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    M_AXI_ARREADY = resetn && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    M_AXI_BVALID  = nb_valid;
    M_AXI_BRESP   = nb_resp;
    M_AXI_RVALID  = nr_valid;
    M_AXI_RDATA   = nr_data;
    M_AXI_RRESP   = 2'b00;
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; rand_mode = 1'b0; stall_aw = 1'b0; err_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_wq.delete();
    resetn = 1'b1;
  endtask

  task automatic pulse_start(input logic rs, input logic lb);
    @(negedge clk);
    cfg_rsfec = rs; cfg_loopback = lb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_bus", 40'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 40'd0);
    chk("rst_flags", 40'({busy, link_up, failed, link_lost}), 40'd0);
    chk("rst_cnt", 40'({retry_count, err_resp}), 40'd0);
    chk("rst_addr_data", 40'({M_AXI_AWADDR, M_AXI_WDATA}), 40'd0);

    // Nominal bring-up, link aligned on first poll
    link_status = 2'b11;
    push_wr(8'h10, 1); push_wr(8'h0C, 1); push_wr(8'h08, 0); push_wr(8'h04, 1);
    r0 = n_reads;
    pulse_start(1'b1, 1'b0);
    for (int i = 0; i < 500 && !link_up; i++) @(negedge clk);
    chk("t1_link_up", 40'(link_up), 40'd1);
    chk("t1_retry", 40'(retry_count), 40'd0);
    chk("t1_reads", 40'(n_reads - r0), 40'd1);
    chk("t1_poll_gap", 40'(ar_cyc - last_b_cyc), 40'(PI + 2));
    chk("t1_wq_left", 40'(exp_wq.size()), 40'd0);
    repeat (3 * PI) @(negedge clk);
`ifdef LINK_MONITOR_EN
    chk("t1_busy_up", 40'(busy), 40'd1);
    chk("t1_polling", 40'(n_reads - r0 > 1), 40'd1);
    push_wr(8'h04, 1);
    link_status = 2'b10;
    for (int i = 0; i < 200 && !link_lost; i++) @(negedge clk);
    chk("mon_lost_pulse", 40'(link_lost), 40'd1);
    chk("mon_up_cleared", 40'(link_up), 40'd0);
    link_status = 2'b11;
    r0 = n_reads; w0 = n_writes;
    @(negedge clk);
    chk("mon_lost_one_cycle", 40'(link_lost), 40'd0);
    for (int i = 0; i < 100 && n_writes == w0; i++) @(negedge clk);
    chk("mon_reset_first", 40'({n_writes - w0, n_reads - r0}), 40'({32'd1, 32'd0}));
    for (int i = 0; i < 500 && !link_up; i++) @(negedge clk);
    chk("mon_reup", 40'(link_up), 40'd1);
    chk("mon_retry", 40'(retry_count), 40'd0);
    chk("mon_wq_left", 40'(exp_wq.size()), 40'd0);
`else
    chk("t1_no_reads_after_up", 40'(n_reads - r0), 40'd1);
    chk("t1_busy_up", 40'(busy), 40'd0);
    chk("t1_link_held", 40'(link_up), 40'd1);
`endif

    // Status stuck on lane0 only: retries exhaust
    do_reset();
    link_status = 2'b01;
    push_wr(8'h10, 1); push_wr(8'h0C, 0); push_wr(8'h08, 1);
    for (int k = 0; k < MR; k++) push_wr(8'h04, 1);
    r0 = n_reads;
    pulse_start(1'b0, 1'b1);
    for (int i = 0; i < 2000 && !failed; i++) @(negedge clk);
    chk("t2_failed", 40'(failed), 40'd1);
    chk("t2_retry", 40'(retry_count), 40'(MR));
    chk("t2_reads", 40'(n_reads - r0), 40'(LT * MR));
    chk("t2_wq_left", 40'(exp_wq.size()), 40'd0);
    chk("t2_err_link", 40'({err_resp, link_up}), 40'd0);
    r0 = n_reads; w0 = n_writes;
    repeat (50) @(negedge clk);
    chk("t2_bus_quiet", 40'((n_reads - r0) + (n_writes - w0)), 40'd0);
    chk("t2_busy", 40'(busy), 40'd0);

    // SLVERR on the RSFEC write, restarted from FAILED
    err_en = 1'b1; err_addr = 8'h0C;
    push_wr(8'h10, 1); push_wr(8'h0C, 1);
    w0 = n_writes;
    pulse_start(1'b1, 1'b1);
    chk("t3_failed_cleared", 40'(failed), 40'd0);
    for (int i = 0; i < 500 && !failed; i++) @(negedge clk);
    chk("t3_failed", 40'(failed), 40'd1);
    chk("t3_err_resp", 40'(err_resp), 40'd2);
    chk("t3_retry_cleared", 40'(retry_count), 40'd0);
    repeat (20) @(negedge clk);
    chk("t3_writes", 40'(n_writes - w0), 40'd2);
    chk("t3_wq_left", 40'(exp_wq.size()), 40'd0);
    err_en = 1'b0;

    // Randomised ready skew and read backpressure
    for (int k = 0; k < 3; k++) begin
      do_reset();
      rand_mode = 1'b1;
      link_status = 2'b11;
      push_wr(8'h10, 1); push_wr(8'h0C, 32'(k & 1)); push_wr(8'h08, 32'((k >> 1) & 1)); push_wr(8'h04, 1);
      pulse_start(1'(k & 1), 1'((k >> 1) & 1));
      for (int i = 0; i < 3000 && !link_up; i++) @(negedge clk);
      chk("t4_link_up", 40'(link_up), 40'd1);
      chk("t4_wq_left", 40'(exp_wq.size()), 40'd0);
    end

    // Reset in the middle of a write
    do_reset();
    stall_aw = 1'b1;
    pulse_start(1'b0, 1'b0);
    for (int i = 0; i < 20 && !M_AXI_AWVALID; i++) @(negedge clk);
    chk("t5_aw_seen", 40'(M_AXI_AWVALID), 40'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_bus_cleared", 40'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 40'd0);
    chk("t5_idle", 40'({busy, failed}), 40'd0);
    stall_aw = 1'b0;
    exp_wq.delete();
    @(negedge clk);
    resetn = 1'b1;

    // Second start while busy is ignored
    link_status = 2'b11;
    push_wr(8'h10, 1); push_wr(8'h0C, 0); push_wr(8'h08, 0); push_wr(8'h04, 1);
    w0 = n_writes;
    pulse_start(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_busy", 40'(busy), 40'd1);
    pulse_start(1'b1, 1'b1);
    for (int i = 0; i < 500 && !link_up; i++) @(negedge clk);
    chk("t6_link_up", 40'(link_up), 40'd1);
    chk("t6_writes", 40'(n_writes - w0), 40'd4);
    chk("t6_wq_left", 40'(exp_wq.size()), 40'd0);

    chk("no_valid_drop", 40'(n_drop), 40'd0);
`ifdef LINK_MONITOR_EN
    chk("lost_pulses", 40'(n_lost), 40'd1);
`else
    chk("lost_pulses", 40'(n_lost), 40'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
